// File: rtl/d_ip_irq_pkg.sv
// d_ip_irq_pkg
// Shared definitions for the interrupt aggregator: register addresses,
// data and counter widths, and the bit positions inside CTRL.
package d_ip_irq_pkg;

    localparam int unsigned IRQ_DW    = 8;
    localparam int unsigned IRQ_CNT_W = 8;
    localparam int unsigned IRQ_AW    = 6;

    localparam logic [IRQ_AW-1:0] IRQ_STATUS  = 6'h00;
    localparam logic [IRQ_AW-1:0] IRQ_ENABLE  = 6'h01;
    localparam logic [IRQ_AW-1:0] IRQ_MODE    = 6'h02;
    localparam logic [IRQ_AW-1:0] IRQ_VECTOR  = 6'h03;
    localparam logic [IRQ_AW-1:0] IRQ_CNT_SEL = 6'h04;
    localparam logic [IRQ_AW-1:0] IRQ_COUNT   = 6'h05;
    localparam logic [IRQ_AW-1:0] IRQ_CTRL    = 6'h06;

    // Bit positions inside the CTRL register.
    typedef enum logic [2:0] {
        CTRL_GEN     = 3'd0,
        CTRL_CLR_ALL = 3'd1
    } ctrl_bit_e;

endpackage

// File: rtl/d_ip_irq_src.sv
// d_ip_irq_src
// One interrupt source: edge register, pending flag and saturating
// rise counter.
// Ports:
//   clk, rst_b : clock, async active-low reset
//   src        : raw source level, synchronous to clk
//   mode       : 1 = edge-triggered pending, 0 = level-triggered pending
//   pend_clr   : clear request for the pending flag (W1C or CLR_ALL)
//   cnt_clr    : clear request for the counter
//   pend       : pending flag
//   cnt        : number of rising edges seen, saturating
module d_ip_irq_src
    import d_ip_irq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 src,
    input  logic                 mode,
    input  logic                 pend_clr,
    input  logic                 cnt_clr,
    output logic                 pend,
    output logic [IRQ_CNT_W-1:0] cnt
);

    logic src_q;
    logic rise;
    logic pend_set;

    assign rise     = src & ~src_q;
    assign pend_set = mode ? rise : src;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            src_q <= 1'b0;
            pend  <= 1'b0;
            cnt   <= '0;
        end else begin
            src_q <= src;

            // A set in the same cycle as a clear wins.
            if (pend_set) begin
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            // A rise coinciding with a clear leaves the count at one.
            if (cnt_clr) begin
                cnt <= rise ? IRQ_CNT_W'(1) : '0;
            end else if (rise && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/d_ip_irq_ctrl.sv
// d_ip_irq_ctrl
// Interrupt aggregator: latches N_SRC sources into pending flags, masks
// them with ENABLE and the global enable, and drives a registered irq
// plus the index of the highest-priority (lowest-index) active source.
// Ports:
//   clk, rst_b     : clock, async active-low reset
//   addr, wr_en,
//   mod_en, wdata  : register write port (write when mod_en & wr_en)
//   rdata          : combinational read data (0 unless mod_en & !wr_en)
//   src_in         : raw interrupt sources
//   irq            : registered interrupt request
//   irq_vec        : index of the highest-priority active source
module d_ip_irq_ctrl
    import d_ip_irq_pkg::*;
#(
    parameter int unsigned N_SRC = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [IRQ_AW-1:0] addr,
    input  logic              wr_en,
    input  logic              mod_en,
    input  logic [IRQ_DW-1:0] wdata,
    output logic [IRQ_DW-1:0] rdata,
    input  logic [N_SRC-1:0]  src_in,
    output logic              irq,
    output logic [2:0]        irq_vec
);

    logic [N_SRC-1:0]                 enable;
    logic [N_SRC-1:0]                 mode;
    logic [2:0]                       cnt_sel;
    logic                             gen;

    logic [N_SRC-1:0]                 pend;
    logic [N_SRC-1:0][IRQ_CNT_W-1:0]  cnt;
    logic [N_SRC-1:0]                 active;

    logic                             wr_acc;
    logic                             clr_all;
    logic                             cnt_wr;
    logic [N_SRC-1:0]                 pend_clr;

    logic                             vec_valid;
    logic [2:0]                       vec_idx;
    logic [IRQ_DW-1:0]                vector;
    logic [IRQ_CNT_W-1:0]             cnt_rd;

    // Upper write-data bits have no home when N_SRC < 8.
    logic                             unused_wdata;
    assign unused_wdata = ^wdata;

    assign wr_acc  = mod_en & wr_en;
    assign clr_all = wr_acc && (addr == IRQ_CTRL) && wdata[CTRL_CLR_ALL];
    assign cnt_wr  = wr_acc && (addr == IRQ_COUNT);

    assign pend_clr = ((wr_acc && (addr == IRQ_STATUS)) ? wdata[N_SRC-1:0] : '0)
                    | {N_SRC{clr_all}};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            enable  <= '0;
            mode    <= '0;
            cnt_sel <= '0;
            gen     <= 1'b0;
        end else if (wr_acc) begin
            case (addr)
                IRQ_ENABLE:  enable  <= wdata[N_SRC-1:0];
                IRQ_MODE:    mode    <= wdata[N_SRC-1:0];
                IRQ_CNT_SEL: cnt_sel <= wdata[2:0];
                IRQ_CTRL:    gen     <= wdata[CTRL_GEN];
                default:     ;
            endcase
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        logic cnt_clr;
        // A CNT_SEL beyond the implemented sources never matches, so
        // COUNT writes then have no effect.
        assign cnt_clr = clr_all | (cnt_wr && (cnt_sel == 3'(g)));

        d_ip_irq_src u_src (
            .clk      (clk),
            .rst_b    (rst_b),
            .src      (src_in[g]),
            .mode     (mode[g]),
            .pend_clr (pend_clr[g]),
            .cnt_clr  (cnt_clr),
            .pend     (pend[g]),
            .cnt      (cnt[g])
        );
    end

    assign active = pend & enable;

    // Lowest index wins.
    always_comb begin
        vec_valid = 1'b0;
        vec_idx   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (active[i] && !vec_valid) begin
                vec_valid = 1'b1;
                vec_idx   = 3'(i);
            end
        end
    end

    assign vector  = {vec_valid, 4'b0000, vec_idx};
    assign irq_vec = vector[2:0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            irq <= 1'b0;
        end else begin
            irq <= gen & (|active);
        end
    end

    always_comb begin
        cnt_rd = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (cnt_sel == 3'(i)) begin
                cnt_rd = cnt[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (mod_en && !wr_en) begin
            case (addr)
                IRQ_STATUS:  rdata = IRQ_DW'(pend);
                IRQ_ENABLE:  rdata = IRQ_DW'(enable);
                IRQ_MODE:    rdata = IRQ_DW'(mode);
                IRQ_VECTOR:  rdata = vector;
                IRQ_CNT_SEL: rdata = IRQ_DW'(cnt_sel);
                IRQ_COUNT:   rdata = cnt_rd;
                IRQ_CTRL:    rdata = IRQ_DW'(gen);
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_d_ip_irq_ctrl.sv
// tb_d_ip_irq_ctrl
// Directed self-checking bench for d_ip_irq_ctrl. Expected values are
// queued as each stimulus step is issued and compared when the DUT
// output is sampled, half a clock away from the rising edge.
module tb_d_ip_irq_ctrl;
    import d_ip_irq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [5:0]  addr;
    logic        wr_en;
    logic        mod_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [2:0]  src_in;
    logic        irq;
    logic [2:0]  irq_vec;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    d_ip_irq_ctrl #(.N_SRC(3)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .addr    (addr),
        .wr_en   (wr_en),
        .mod_en  (mod_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .src_in  (src_in),
        .irq     (irq),
        .irq_vec (irq_vec)
    );

    task automatic push_exp(input string tag, input logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_cmp(input logic [7:0] obs);
        exp_t x;
        x.tag = "sb_empty";
        x.exp = 8'hxx;
        if (sb.size() != 0) x = sb.pop_front();
        checks++;
        assert (obs === x.exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", x.tag, obs, x.exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        addr   = a;
        wdata  = d;
        mod_en = 1'b1;
        wr_en  = 1'b1;
        @(negedge clk);
        wr_en  = 1'b0;
        mod_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] e, input string tag);
        addr   = a;
        mod_en = 1'b1;
        wr_en  = 1'b0;
        push_exp(tag, e);
        #1;
        pop_cmp(rdata);
        mod_en = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string tag);
        push_exp(tag, {7'd0, e});
        #1;
        pop_cmp({7'd0, irq});
    endtask

    task automatic chk_vec(input logic [2:0] e, input string tag);
        push_exp(tag, {5'd0, e});
        #1;
        pop_cmp({5'd0, irq_vec});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b  = 1'b0;
        addr   = '0;
        wr_en  = 1'b0;
        mod_en = 1'b0;
        wdata  = '0;
        src_in = '0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();

        // Reset state
        for (int a = 0; a <= 6; a++) rd(6'(a), 8'h00, "reset_reg");
        chk_irq(1'b0, "reset_irq");
        chk_vec(3'd0, "reset_vec");

        // Edge mode, single-cycle pulse on source 1
        wr(IRQ_MODE, 8'h07);
        wr(IRQ_ENABLE, 8'h02);
        wr(IRQ_CTRL, 8'h01);
        src_in = 3'b010;
        tick();
        src_in = 3'b000;
        rd(IRQ_STATUS, 8'h02, "pulse_status");
        rd(IRQ_VECTOR, 8'h81, "pulse_vector");
        chk_vec(3'd1, "pulse_irq_vec");
        chk_irq(1'b0, "irq_not_yet");
        tick();
        chk_irq(1'b1, "irq_one_later");
        wr(IRQ_STATUS, 8'h02);
        rd(IRQ_STATUS, 8'h00, "w1c_status");
        chk_irq(1'b1, "irq_still_high");
        tick();
        chk_irq(1'b0, "irq_dropped");

        // Level mode: held source overrides W1C
        wr(IRQ_MODE, 8'h00);
        src_in = 3'b001;
        tick();
        rd(IRQ_STATUS, 8'h01, "level_set");
        wr(IRQ_STATUS, 8'h01);
        rd(IRQ_STATUS, 8'h01, "level_override");
        src_in = 3'b000;
        wr(IRQ_STATUS, 8'h01);
        rd(IRQ_STATUS, 8'h00, "level_cleared");

        // Set beats W1C in the same cycle
        src_in = 3'b100;
        wr(IRQ_STATUS, 8'h04);
        src_in = 3'b000;
        rd(IRQ_STATUS, 8'h04, "set_beats_clr");

        // Priority
        wr(IRQ_ENABLE, 8'h05);
        src_in = 3'b001;
        tick();
        src_in = 3'b000;
        rd(IRQ_STATUS, 8'h05, "two_pending");
        rd(IRQ_VECTOR, 8'h80, "prio_low_wins");
        chk_irq(1'b1, "irq_prio");
        addr   = IRQ_STATUS;
        mod_en = 1'b0;
        push_exp("no_sel_read", 8'h00);
        #1;
        pop_cmp(rdata);
        wr(IRQ_STATUS, 8'h01);
        rd(IRQ_VECTOR, 8'h82, "prio_next");
        chk_vec(3'd2, "prio_irq_vec");

        // Counter and CLR_ALL
        wr(IRQ_CNT_SEL, 8'h02);
        rd(IRQ_COUNT, 8'h01, "cnt2_one");
        wr(IRQ_CTRL, 8'h03);
        rd(IRQ_STATUS, 8'h00, "clr_all_status");
        rd(IRQ_CTRL, 8'h01, "ctrl_readback");
        rd(IRQ_COUNT, 8'h00, "clr_all_cnt");

        // Saturation
        wr(IRQ_CNT_SEL, 8'h00);
        for (int i = 0; i < 300; i++) begin
            src_in = 3'b001;
            tick();
            src_in = 3'b000;
            tick();
        end
        rd(IRQ_COUNT, 8'hFF, "cnt_saturate");
        wr(IRQ_COUNT, 8'h55);
        rd(IRQ_COUNT, 8'h00, "cnt_wr_clear");
        src_in = 3'b001;
        tick();
        src_in = 3'b000;
        wr(IRQ_CNT_SEL, 8'h05);
        rd(IRQ_COUNT, 8'h00, "cnt_sel_oob");
        wr(IRQ_COUNT, 8'h00);
        wr(IRQ_CNT_SEL, 8'h00);
        rd(IRQ_COUNT, 8'h01, "cnt_oob_wr_ignored");

        // Unimplemented bits and addresses
        wr(IRQ_ENABLE, 8'hFF);
        rd(IRQ_ENABLE, 8'h07, "enable_mask");
        wr(6'h3F, 8'hFF);
        rd(6'h3F, 8'h00, "unmapped");
        rd(6'h07, 8'h00, "unmapped_7");

        // Asynchronous reset with irq high
        chk_irq(1'b1, "irq_before_rst");
        src_in = 3'b100;
        #2;
        rst_b = 1'b0;
        #1;
        chk_irq(1'b0, "irq_async_rst");
        chk_vec(3'd0, "vec_async_rst");
        for (int a = 0; a <= 6; a++) rd(6'(a), 8'h00, "rst_reg");
        tick();
        rst_b = 1'b1;
        tick();
        rd(IRQ_STATUS, 8'h04, "rise_at_release");
        wr(IRQ_CNT_SEL, 8'h02);
        rd(IRQ_COUNT, 8'h01, "cnt_at_release");
        src_in = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d_ip_irq_ctrl.md
# d_ip_irq_ctrl

Interrupt aggregator sitting directly downstream of `d_ip_timer`. It consumes the timer's `overflow_int`, `comp_0_match_int` and `comp_1_match_int` lines, plus any further sources, and latches them into per-source pending flags. It applies enable masking and a global enable, then drives one registered `irq` line and a priority vector to the CPU. Software programs and services it through the same 6-bit address / 8-bit data register port used by the timer.

## Interface
- `N_SRC`, 3: number of interrupt sources, legal range 1..8; bit 0 = overflow, bit 1 = match0, bit 2 = match1 when wired to the timer.
- `clk` in 1: system clock, all logic rising-edge.
- `rst_b` in 1: reset, asynchronous assert, active-low; single clock, no other clock domain.
- `addr` in 6: register address.
- `wr_en` in 1: write strobe, qualified by `mod_en`.
- `mod_en` in 1: module select.
- `wdata` in 8: write data.
- `rdata` out 8: read data, combinational.
- `src_in` in N_SRC: raw interrupt sources, synchronous to `clk`.
- `irq` out 1: registered interrupt request.
- `irq_vec` out 3: index of the highest-priority active source; equals VECTOR[2:0].

## Operation
- Write access occurs on the `clk` edge when `mod_en & wr_en`.
- `rdata` = selected register when `mod_en & !wr_en`, else 0. Unmapped addresses read 0 and ignore writes.
- Bits at index ≥ N_SRC read 0 and ignore writes.
- Register map:
  - 0x00 STATUS: pending flags, R/W1C.
  - 0x01 ENABLE: R/W.
  - 0x02 MODE: R/W; 1 = edge, 0 = level.
  - 0x03 VECTOR: RO. Bit7 = valid; bits[2:0] = lowest index with STATUS & ENABLE set; 0x00 when none.
  - 0x04 CNT_SEL: R/W, bits[2:0].
  - 0x05 COUNT: RO read of the selected source counter; any write clears that counter.
  - 0x06 CTRL: bit0 GEN, the global enable, R/W. Bit1 CLR_ALL reads 0; writing 1 clears all STATUS bits and counters.
- Edge detect: `src_q` holds the previous sample of `src_in`; rise = `src_in & ~src_q`.
- Pending set:
  - Edge mode: on rise.
  - Level mode: every cycle `src_in` is high.
  - Level mode with source still high: a W1C clear is overridden, and the bit re-sets.
- Set beats clear: a set and a W1C clear in the same cycle leave the bit at 1. The same holds against CLR_ALL.
- STATUS is unmasked. ENABLE only gates `irq` and VECTOR.
- Counters: one per source, 8-bit, saturating at 0xFF.
  - They increment on every rise, independent of MODE and ENABLE.
  - A rise in the same cycle as a counter clear leaves the counter at 1.
- `irq` next value = GEN & |(STATUS & ENABLE), computed from the registered STATUS.
- Priority: lowest index wins.
- CNT_SEL ≥ N_SRC: COUNT reads 0, and a write to COUNT has no effect.

## Timing
- Reset: all registers 0, `src_q` 0, `irq` 0, `irq_vec` 0, `rdata` 0.
  - A source already high at reset release is detected as a rise on the first sampling edge.
- Source high sampled at edge k → STATUS bit and counter updated after edge k.
- VECTOR and `irq_vec` are combinational from STATUS and ENABLE, so they update after edge k.
- `irq` asserts after edge k+1, one cycle of latency.
- W1C on edge k → STATUS clear after k; `irq` deasserts after k+1.
- Changes to ENABLE or GEN reach `irq` with the same one-cycle latency.
- A single-cycle timer pulse, as produced by `d_ip_timer`, is captured in either mode.
- Reset mid-operation clears everything immediately (asynchronous); `irq` drops without waiting for a clock.

## Structure
- Package `d_ip_irq_pkg` holds:
  - register address localparams (`IRQ_STATUS` … `IRQ_CTRL`);
  - `IRQ_DW = 8`;
  - `IRQ_CNT_W = 8`;
  - a CTRL bit-position enum (GEN, CLR_ALL).
- Sub-module `d_ip_irq_src`: one per source, instantiated in a generate loop.
  - Contains: edge register, pending flop with set/clear priority, saturating counter.
  - Outputs: `pend`, `cnt[7:0]`.
- Top level contains: register decode, read mux, priority encoder, `irq` flop.

## Test plan
- Reset, then read 0x00–0x06: all return 0x00; `irq` = 0, `irq_vec` = 0.
- MODE = 0x07, ENABLE = 0x02, GEN = 1, one-cycle pulse on `src_in[1]`:
  - STATUS = 0x02 and VECTOR = 0x81;
  - `irq` goes high exactly one cycle after STATUS;
  - write STATUS = 0x02 → STATUS = 0x00, and `irq` low one cycle later.
- MODE = 0, hold `src_in[0]` high, write STATUS = 0x01 → STATUS stays 0x01. Drop the source, then W1C → STATUS = 0x00.
- Pulse `src_in[2]` in the same cycle as a W1C of bit 2 → STATUS[2] = 1.
- With ENABLE = 0x05 and sources 0 and 2 both pending → VECTOR = 0x80. Clear bit 0 → VECTOR = 0x82.
- 300 rises on `src_in[0]`, CNT_SEL = 0 → COUNT reads 0xFF.
  - Write COUNT → it reads 0x00.
  - CNT_SEL = 5 with N_SRC = 3 → COUNT reads 0x00.
- Assert `rst_b` low mid-burst with `irq` high → `irq` = 0 before the next `clk` edge and all registers read 0.
